// File: rtl/turn_controller_pkg.sv
// Shared phase and result codes for the battle sequencer and the stages it drives.
package game_pkg;

  // One-hot phase codes as seen on the enemy stage's state input.
  typedef enum logic [3:0] {
    TITLE  = 4'b0001,
    PLAYER = 4'b0010,
    RESULT = 4'b0100,
    ENEMY  = 4'b1000
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_WIN  = 2'b01,
    RES_LOSE = 2'b10,
    RES_DRAW = 2'b11
  } result_t;

  localparam int TURN_W = 4;

endpackage

// File: rtl/turn_controller_if.sv
// Handshake bundle between the turn controller and its neighbours.
// master = the side that produces the events, slave = the controller.
interface turn_controller_if;
  import game_pkg::*;

  logic               new_frame_in;
  logic               start_in;
  logic               player_done_in;
  logic               player_hp_zero_in;
  logic               enemy_hp_zero_in;
  logic               enemy_busy_in;
  logic               enemy_finished_in;
  state_t             state_out;
  logic [TURN_W-1:0]  turn_out;
  result_t            result_out;
  logic               timeout_out;

  modport master (
    output new_frame_in, start_in, player_done_in, player_hp_zero_in,
           enemy_hp_zero_in, enemy_busy_in, enemy_finished_in,
    input  state_out, turn_out, result_out, timeout_out
  );

  modport slave (
    input  new_frame_in, start_in, player_done_in, player_hp_zero_in,
           enemy_hp_zero_in, enemy_busy_in, enemy_finished_in,
    output state_out, turn_out, result_out, timeout_out
  );

endinterface

// File: rtl/turn_controller_watchdog.sv
// Cycle counter that flags a stalled enemy phase. ENEMY_TIMEOUT must be >= 2.
module turn_watchdog #(
  parameter int ENEMY_TIMEOUT = 6_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = $clog2(ENEMY_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(ENEMY_TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles; a commit or a busy enemy restarts the count from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear || hold) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expire = enable && (r_count == LAST);

endmodule

// File: rtl/turn_controller.sv
// Battle phase sequencer: registers phase requests and commits them on frame pulses.
module turn_controller
  import game_pkg::*;
#(
  parameter int MAX_TURNS     = 15,
  parameter int ENEMY_TIMEOUT = 6_500_000
) (
  input  logic             clk,
  input  logic             rst,
  turn_controller_if.slave bus
);

  localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(MAX_TURNS - 1);

  state_t             r_state, w_state_next;
  state_t             r_pend_state, w_pend_state_next;
  result_t            r_result, w_result_next;
  result_t            r_pend_result, w_pend_result_next;
  logic [TURN_W-1:0]  r_turn, w_turn_next;
  logic               r_timeout, w_timeout_next;
  logic               r_pend_valid, w_pend_valid_next;

  logic               w_commit;
  logic               w_expire;
  logic               w_wd_enable;
  logic               w_hp_event;
  result_t            w_hp_result;

  assign w_commit    = bus.new_frame_in && r_pend_valid;
  assign w_wd_enable = (r_state == ENEMY) && !r_pend_valid;

  turn_watchdog #(
    .ENEMY_TIMEOUT (ENEMY_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_commit),
    .hold   (bus.enemy_busy_in),
    .enable (w_wd_enable),
    .expire (w_expire)
  );

  // HP-zero detection is shared by the player and enemy phases.
  always_comb begin
    w_hp_event  = ((r_state == PLAYER) || (r_state == ENEMY)) &&
                  (bus.enemy_hp_zero_in || bus.player_hp_zero_in);
    w_hp_result = RES_LOSE;
    if (bus.enemy_hp_zero_in && bus.player_hp_zero_in) begin
      w_hp_result = RES_DRAW;
    end else if (bus.enemy_hp_zero_in) begin
      w_hp_result = RES_WIN;
    end
  end

  // Next-state: apply a due commit, then register at most one new request.
  always_comb begin
    w_state_next       = r_state;
    w_result_next      = r_result;
    w_turn_next        = r_turn;
    w_timeout_next     = r_timeout;
    w_pend_valid_next  = r_pend_valid;
    w_pend_state_next  = r_pend_state;
    w_pend_result_next = r_pend_result;

    if (w_commit) begin
      w_state_next      = r_pend_state;
      w_result_next     = r_pend_result;
      w_pend_valid_next = 1'b0;
      if (r_pend_state == PLAYER) begin
        if (r_state == TITLE) begin
          w_turn_next    = '0;
          w_timeout_next = 1'b0;
        end else if (r_turn != '1) begin
          w_turn_next = r_turn + TURN_W'(1);
        end
      end
    end

    // A decided battle outcome must never be replaced by a later event.
    if (w_hp_event && !(r_pend_valid && (r_pend_state == RESULT))) begin
      w_pend_valid_next  = 1'b1;
      w_pend_state_next  = RESULT;
      w_pend_result_next = w_hp_result;
    end else if (!r_pend_valid) begin
      case (r_state)
        TITLE: begin
          if (bus.start_in) begin
            w_pend_valid_next  = 1'b1;
            w_pend_state_next  = PLAYER;
            w_pend_result_next = RES_NONE;
          end
        end
        PLAYER: begin
          if (bus.player_done_in) begin
            w_pend_valid_next  = 1'b1;
            w_pend_state_next  = ENEMY;
            w_pend_result_next = RES_NONE;
          end
        end
        ENEMY: begin
          if (bus.enemy_finished_in || w_expire) begin
            w_pend_valid_next = 1'b1;
            if (r_turn == LAST_TURN) begin
              w_pend_state_next  = RESULT;
              w_pend_result_next = RES_DRAW;
            end else begin
              w_pend_state_next  = PLAYER;
              w_pend_result_next = RES_NONE;
            end
            if (w_expire) begin
              w_timeout_next = 1'b1;
            end
          end
        end
        RESULT: begin
          if (bus.start_in) begin
            w_pend_valid_next  = 1'b1;
            w_pend_state_next  = TITLE;
            w_pend_result_next = RES_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= TITLE;
      r_result      <= RES_NONE;
      r_turn        <= '0;
      r_timeout     <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_state  <= TITLE;
      r_pend_result <= RES_NONE;
    end else begin
      r_state       <= w_state_next;
      r_result      <= w_result_next;
      r_turn        <= w_turn_next;
      r_timeout     <= w_timeout_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_state  <= w_pend_state_next;
      r_pend_result <= w_pend_result_next;
    end
  end

  assign bus.state_out   = r_state;
  assign bus.turn_out    = r_turn;
  assign bus.result_out  = r_result;
  assign bus.timeout_out = r_timeout;

endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller: stimulus queues expected output changes,
// a monitor compares each observed change (value and commit cycle) against them.
module tb_turn_controller;

  localparam logic [3:0] S_TITLE  = 4'b0001;
  localparam logic [3:0] S_PLAYER = 4'b0010;
  localparam logic [3:0] S_RESULT = 4'b0100;
  localparam logic [3:0] S_ENEMY  = 4'b1000;
  localparam logic [1:0] R_NONE   = 2'b00;
  localparam logic [1:0] R_WIN    = 2'b01;
  localparam logic [1:0] R_LOSE   = 2'b10;
  localparam logic [1:0] R_DRAW   = 2'b11;

  typedef struct {
    logic [3:0] st;
    logic [3:0] tn;
    logic [1:0] rs;
    logic       to;
    int         due;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b1;
  exp_t q[$];

  turn_controller_if bus();

  turn_controller #(
    .MAX_TURNS     (4),
    .ENEMY_TIMEOUT (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] pack_out();
    return {bus.state_out, bus.turn_out, bus.result_out, bus.timeout_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [3:0] st, input logic [3:0] tn, input logic [1:0] rs,
                            input logic to, input int due, input string name);
    exp_t e;
    e.st = st; e.tn = tn; e.rs = rs; e.to = to; e.due = due; e.name = name;
    q.push_back(e);
  endtask

  task automatic frame(output int c);
    bus.new_frame_in = 1'b1;
    tick();
    bus.new_frame_in = 1'b0;
    c = cyc;
  endtask

  task automatic pulse_start();
    bus.start_in = 1'b1; tick(); bus.start_in = 1'b0;
  endtask

  task automatic pulse_done();
    bus.player_done_in = 1'b1; tick(); bus.player_done_in = 1'b0;
  endtask

  task automatic pulse_fin();
    bus.enemy_finished_in = 1'b1; tick(); bus.enemy_finished_in = 1'b0;
  endtask

  task automatic check_now(input string name, input logic [10:0] got, input logic [10:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got st/tn/rs/to=%b want %b", name, got, want);
    end else begin
      $display("ok   %s: st/tn/rs/to=%b", name, got);
    end
  endtask

  // Monitor: every output change must match the next queued expectation and its cycle.
  initial begin : monitor
    logic [10:0] prev;
    logic [10:0] cur;
    exp_t        e;
    prev = {S_TITLE, 4'd0, R_NONE, 1'b0};
    forever begin
      @(negedge clk);
      cur = pack_out();
      if (mon_en && (cur !== prev)) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: got %b at cycle %0d, want no change", cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== {e.st, e.tn, e.rs, e.to} || cyc != e.due) begin
            bad++;
            $display("FAIL %s: got st=%b tn=%0d rs=%b to=%b @%0d want st=%b tn=%0d rs=%b to=%b @%0d",
                     e.name, cur[10:7], cur[6:3], cur[2:1], cur[0], cyc,
                     e.st, e.tn, e.rs, e.to, e.due);
          end else begin
            $display("ok   %s: st=%b tn=%0d rs=%b to=%b @%0d", e.name, e.st, e.tn, e.rs, e.to, cyc);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got no finish by 200us, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int   c;
    exp_t e;
    bus.new_frame_in      = 1'b0;
    bus.start_in          = 1'b0;
    bus.player_done_in    = 1'b0;
    bus.player_hp_zero_in = 1'b0;
    bus.enemy_hp_zero_in  = 1'b0;
    bus.enemy_busy_in     = 1'b0;
    bus.enemy_finished_in = 1'b0;

    repeat (3) tick();
    check_now("reset_state", pack_out(), {S_TITLE, 4'd0, R_NONE, 1'b0});
    rst = 1'b1;
    repeat (2) tick();

    // Title: unconsumed pulses and an empty frame change nothing.
    pulse_done();
    pulse_fin();
    frame(c);
    tick();
    // Start, frame two cycles later.
    pulse_start();
    tick();
    frame(c);
    expect_out(S_PLAYER, 4'd0, R_NONE, 1'b0, c, "title_to_player");

    // Event coinciding with a frame is only registered.
    bus.player_done_in = 1'b1;
    bus.new_frame_in   = 1'b1;
    tick();
    bus.player_done_in = 1'b0;
    bus.new_frame_in   = 1'b0;
    repeat (3) tick();
    frame(c);
    expect_out(S_ENEMY, 4'd0, R_NONE, 1'b0, c, "player_to_enemy_late");

    // Three enemy/player rounds; the second keeps the enemy busy well past the timeout.
    for (int k = 1; k <= 3; k++) begin
      if (k == 2) begin
        bus.enemy_busy_in = 1'b1;
        repeat (25) tick();
        bus.enemy_finished_in = 1'b1;
        tick();
        bus.enemy_finished_in = 1'b0;
        bus.enemy_busy_in     = 1'b0;
      end else begin
        pulse_fin();
      end
      tick();
      frame(c);
      expect_out(S_PLAYER, 4'(k), R_NONE, 1'b0, c, $sformatf("turn_%0d", k));
      pulse_done();
      frame(c);
      expect_out(S_ENEMY, 4'(k), R_NONE, 1'b0, c, $sformatf("enemy_%0d", k));
    end

    // Last allowed turn finishes: draw; a second finish while pending is ignored.
    pulse_fin();
    pulse_fin();
    frame(c);
    expect_out(S_RESULT, 4'd3, R_DRAW, 1'b0, c, "max_turn_draw");

    // Asynchronous reset mid-cycle with a pending request in flight.
    pulse_done();
    pulse_start();
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check_now("async_reset", pack_out(), {S_TITLE, 4'd0, R_NONE, 1'b0});
    repeat (2) tick();
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    frame(c);
    repeat (2) tick();
    check_now("pending_discarded", pack_out(), {S_TITLE, 4'd0, R_NONE, 1'b0});

    // Watchdog: stalled enemy phase forces the next turn.
    pulse_start();
    frame(c);
    expect_out(S_PLAYER, 4'd0, R_NONE, 1'b0, c, "restart_player");
    pulse_done();
    frame(c);
    expect_out(S_ENEMY, 4'd0, R_NONE, 1'b0, c, "enemy_stall");
    expect_out(S_ENEMY, 4'd0, R_NONE, 1'b1, c + 20, "watchdog_fire");
    repeat (25) tick();
    frame(c);
    expect_out(S_PLAYER, 4'd1, R_NONE, 1'b1, c, "watchdog_player");

    // Enemy HP zero overrides a pending enemy request.
    pulse_done();
    tick();
    bus.enemy_hp_zero_in = 1'b1;
    tick();
    frame(c);
    bus.enemy_hp_zero_in = 1'b0;
    expect_out(S_RESULT, 4'd1, R_WIN, 1'b1, c, "hp_win_override");
    pulse_start();
    frame(c);
    expect_out(S_TITLE, 4'd1, R_NONE, 1'b1, c, "result_to_title");
    pulse_start();
    frame(c);
    expect_out(S_PLAYER, 4'd0, R_NONE, 1'b0, c, "title_clears");

    // Player HP zero; a later enemy HP zero cannot overwrite the pending result.
    bus.player_hp_zero_in = 1'b1;
    tick();
    bus.enemy_hp_zero_in = 1'b1;
    tick();
    frame(c);
    bus.player_hp_zero_in = 1'b0;
    bus.enemy_hp_zero_in  = 1'b0;
    expect_out(S_RESULT, 4'd0, R_LOSE, 1'b0, c, "hp_lose_kept");
    pulse_start();
    frame(c);
    expect_out(S_TITLE, 4'd0, R_NONE, 1'b0, c, "lose_to_title");
    pulse_start();
    frame(c);
    expect_out(S_PLAYER, 4'd0, R_NONE, 1'b0, c, "again_player");

    // Both HP zero during the enemy phase: draw.
    pulse_done();
    frame(c);
    expect_out(S_ENEMY, 4'd0, R_NONE, 1'b0, c, "again_enemy");
    bus.player_hp_zero_in = 1'b1;
    bus.enemy_hp_zero_in  = 1'b1;
    tick();
    frame(c);
    bus.player_hp_zero_in = 1'b0;
    bus.enemy_hp_zero_in  = 1'b0;
    expect_out(S_RESULT, 4'd0, R_DRAW, 1'b0, c, "hp_both_draw");

    repeat (5) tick();
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: got no output change, want st=%b tn=%0d rs=%b to=%b @%0d",
               e.name, e.st, e.tn, e.rs, e.to, e.due);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
